// File: rtl/dvs_event_fifo_arbiter_if.sv
// Producer request/grant bus plus show-ahead read port of the DVS event FIFO arbiter.
interface dvs_event_fifo_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int EVENT_W = 16,
  parameter int DEPTH   = 16
);
  logic [NUM_REQ-1:0]         fifo_req;
  logic [NUM_REQ*EVENT_W-1:0] fifo_bus_event;
  logic [NUM_REQ-1:0]         fifo_grant;
  logic                       rd_valid;
  logic [EVENT_W-1:0]         rd_data;
  logic                       rd_ready;
  logic [$clog2(DEPTH):0]     count;
  logic                       full;
  logic                       empty;

  modport slave (
    input  fifo_req, fifo_bus_event, rd_ready,
    output fifo_grant, rd_valid, rd_data, count, full, empty
  );

  modport master (
    output fifo_req, fifo_bus_event, rd_ready,
    input  fifo_grant, rd_valid, rd_data, count, full, empty
  );
endinterface

// File: rtl/dvs_event_fifo_arbiter.sv
// Round-robin arbiter over NUM_REQ event producers feeding a circular FIFO.
// Grants are withheld while full so no event is lost.
module dvs_event_fifo_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int EVENT_W = 16,
  parameter int DEPTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  dvs_event_fifo_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]         r_state;
  logic [IDX_W-1:0]   r_win;
  logic [IDX_W-1:0]   r_rr;
  logic [NUM_REQ-1:0] r_grant;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_full;
  logic               r_empty;
  logic [EVENT_W-1:0] r_mem [DEPTH];

  logic               w_sel_found;
  logic [IDX_W-1:0]   w_sel_idx;
  logic [IDX_W-1:0]   w_rr_nxt;
  logic [NUM_REQ-1:0] w_onehot;
  logic               w_push;
  logic               w_pop;
  logic [EVENT_W-1:0] w_push_data;
  logic [CNT_W-1:0]   w_count_nxt;

  // First requester at or after the round-robin pointer, scanning upward with wrap.
  always_comb begin
    int j;
    j           = 0;
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(r_rr) + k;
      j = (j >= NUM_REQ) ? (j - NUM_REQ) : j;
      if (!w_sel_found && bus.fifo_req[IDX_W'(j)]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(j);
      end else begin
        w_sel_found = w_sel_found;
      end
    end
  end

  // Push/pop qualification and next occupancy; full uses the pre-edge count.
  always_comb begin
    w_onehot            = '0;
    w_onehot[w_sel_idx] = 1'b1;
    w_rr_nxt    = (w_sel_idx == LAST_IDX) ? '0 : (w_sel_idx + IDX_W'(1));
    w_push      = (r_state == ST_IDLE) && w_sel_found && !r_full;
    w_pop       = bus.rd_ready && !r_empty;
    w_push_data = bus.fifo_bus_event[w_sel_idx*EVENT_W +: EVENT_W];
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Grant FSM: one push per grant, hold while the winner keeps requesting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_win   <= '0;
      r_rr    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_push) begin
            r_grant <= w_onehot;
            r_win   <= w_sel_idx;
            r_rr    <= w_rr_nxt;
            r_state <= ST_GRANT;
          end else begin
            r_grant <= '0;
          end
        end
        ST_GRANT: begin
          if (bus.fifo_req[r_win]) begin
            r_grant <= r_grant;
          end else begin
            r_grant <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_grant <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_push ? (r_wr_ptr + PTR_W'(1)) : r_wr_ptr;
      r_rd_ptr <= w_pop  ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == DEPTH_C);
      r_empty  <= (w_count_nxt == '0);
    end
  end

  // Event storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  assign bus.fifo_grant = r_grant;
  assign bus.rd_valid   = ~r_empty;
  assign bus.rd_data    = r_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.count      = r_count;
  assign bus.full       = r_full;
  assign bus.empty      = r_empty;
endmodule

// File: tb/tb_dvs_event_fifo_arbiter.sv
// Directed bench for dvs_event_fifo_arbiter with a read-side scoreboard monitor.
module tb_dvs_event_fifo_arbiter;
  localparam int NR = 2;
  localparam int EW = 12;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [EW-1:0] exp_q [$];
  logic [EW-1:0] ev0, ev1;

  dvs_event_fifo_arbiter_if #(.NUM_REQ(NR), .EVENT_W(EW), .DEPTH(DP)) bus ();

  dvs_event_fifo_arbiter #(.NUM_REQ(NR), .EVENT_W(EW), .DEPTH(DP)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ev(input logic [EW-1:0] e0, input logic [EW-1:0] e1);
    ev0 = e0;
    ev1 = e1;
    bus.fifo_bus_event = {e1, e0};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.fifo_req = '0;
    bus.rd_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Scoreboard: every accepted pop must present the oldest expected event.
  always @(negedge clk) begin
    if (!rst && bus.rd_valid && bus.rd_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got %0h want none", bus.rd_data);
      end else begin
        chk("pop_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_g [10] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    logic [2:0] exp_c [10] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4};
    logic [EW-1:0] ev;

    set_ev(12'h000, 12'h000);
    do_reset();
    chk("rst_grant", 32'(bus.fifo_grant), 32'h0);
    chk("rst_valid", 32'(bus.rd_valid), 32'h0);
    chk("rst_data", 32'(bus.rd_data), 32'h0);
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_full", 32'(bus.full), 32'h0);
    chk("rst_empty", 32'(bus.empty), 32'h1);

    // Single request, grant after one edge, drop releases grant.
    set_ev(12'h0A5, 12'h000);
    bus.fifo_req = 2'b01;
    exp_q.push_back(12'h0A5);
    tick();
    chk("t1_grant", 32'(bus.fifo_grant), 32'h1);
    chk("t1_valid", 32'(bus.rd_valid), 32'h1);
    chk("t1_data", 32'(bus.rd_data), 32'h0A5);
    chk("t1_count", 32'(bus.count), 32'h1);
    bus.fifo_req = 2'b00;
    tick();
    chk("t1_release", 32'(bus.fifo_grant), 32'h0);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    chk("t1_empty", 32'(bus.empty), 32'h1);

    // Continuous demand from both producers fills the FIFO round-robin.
    do_reset();
    set_ev(12'h011, 12'h022);
    exp_q.push_back(12'h011);
    exp_q.push_back(12'h022);
    exp_q.push_back(12'h011);
    exp_q.push_back(12'h022);
    bus.fifo_req = 2'b11;
    for (int e = 0; e < 10; e++) begin
      tick();
      chk($sformatf("t2_grant%0d", e), 32'(bus.fifo_grant), 32'(exp_g[e]));
      chk($sformatf("t2_count%0d", e), 32'(bus.count), 32'(exp_c[e]));
      bus.fifo_req = ~bus.fifo_grant;
    end
    chk("t2_full", 32'(bus.full), 32'h1);

    // Pop from full: grant only at the edge after the count drops.
    bus.fifo_req = 2'b10;
    bus.rd_ready = 1'b1;
    exp_q.push_back(12'h022);
    tick();
    bus.rd_ready = 1'b0;
    chk("t3_nogrant", 32'(bus.fifo_grant), 32'h0);
    chk("t3_count3", 32'(bus.count), 32'h3);
    tick();
    chk("t3_grant1", 32'(bus.fifo_grant), 32'h2);
    chk("t3_count4", 32'(bus.count), 32'h4);
    bus.fifo_req = 2'b00;
    tick();
    chk("t3_release", 32'(bus.fifo_grant), 32'h0);

    // Drain to one entry, then push and pop at the same edge.
    bus.rd_ready = 1'b1;
    repeat (3) tick();
    chk("t4_count1", 32'(bus.count), 32'h1);
    set_ev(12'h033, 12'h022);
    bus.fifo_req = 2'b01;
    exp_q.push_back(12'h033);
    tick();
    chk("t4_grant", 32'(bus.fifo_grant), 32'h1);
    chk("t4_count", 32'(bus.count), 32'h1);
    chk("t4_data", 32'(bus.rd_data), 32'h033);
    bus.fifo_req = 2'b00;
    tick();
    bus.rd_ready = 1'b0;
    chk("t4_empty", 32'(bus.empty), 32'h1);

    // Eight push/pop pairs wrap both pointers twice.
    for (int k = 0; k < 8; k++) begin
      ev = 12'h100 + 12'(k);
      set_ev(ev, 12'h000);
      exp_q.push_back(ev);
      bus.fifo_req = 2'b01;
      tick();
      chk($sformatf("t5_head%0d", k), 32'(bus.rd_data), 32'(ev));
      bus.fifo_req = 2'b00;
      bus.rd_ready = 1'b1;
      tick();
      bus.rd_ready = 1'b0;
    end
    chk("t5_empty", 32'(bus.empty), 32'h1);

    // Build count=3 with producer 1 granted, then reset mid-handshake.
    set_ev(12'h044, 12'h055);
    for (int p = 0; p < 3; p++) begin
      bus.fifo_req = (p == 1) ? 2'b10 : 2'b01;
      exp_q.push_back((p == 1) ? ev1 : ev0);
      tick();
      bus.fifo_req = 2'b00;
      tick();
    end
    bus.fifo_req = 2'b10;
    bus.rd_ready = 1'b1;
    exp_q.push_back(12'h055);
    tick();
    bus.rd_ready = 1'b0;
    chk("t6_grant1", 32'(bus.fifo_grant), 32'h2);
    chk("t6_count3", 32'(bus.count), 32'h3);
    rst = 1'b1;
    tick();
    chk("t6_rst_grant", 32'(bus.fifo_grant), 32'h0);
    chk("t6_rst_count", 32'(bus.count), 32'h0);
    chk("t6_rst_empty", 32'(bus.empty), 32'h1);
    chk("t6_rst_valid", 32'(bus.rd_valid), 32'h0);
    exp_q.delete();
    rst = 1'b0;
    set_ev(12'h066, 12'h077);
    bus.fifo_req = 2'b11;
    exp_q.push_back(12'h066);
    tick();
    chk("t6_first", 32'(bus.fifo_grant), 32'h1);
    chk("t6_data", 32'(bus.rd_data), 32'h066);
    bus.fifo_req = 2'b00;
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
